window_scan_ctrl: RTL and testbench

Sequencing controller for the 3x3 window datapath (line-buffer taps feeding three 3-tap hold stages). It tracks row and column position of the incoming pixel stream and gates the window shift. It qualifies each window output with valid, coordinate and border flags, aligned to the datapath latency. It sits between the pixel source and the downstream per-window consumer (DoG and extrema stages).

---
 rtl/window_scan_ctrl_if.sv | 23 ++
 rtl/window_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_window_scan_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_scan_ctrl_if.sv
// Pixel-stream control and per-window qualifier signals shared by the source, the scan controller and the consumer.
interface window_scan_ctrl_if;
    logic       ivalid;
    logic       isof;
    logic       oshift_en;
    logic       ovalid;
    logic [9:0] ocol;
    logic [8:0] orow;
    logic       oborder;
    logic       oframe_done;
    logic       oerr_sof;
    logic       obusy;

    modport master (
        output ivalid, isof,
        input  oshift_en, ovalid, ocol, orow, oborder, oframe_done, oerr_sof, obusy
    );

    modport slave (
        input  ivalid, isof,
        output oshift_en, ovalid, ocol, orow, oborder, oframe_done, oerr_sof, obusy
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// 3x3 window scan controller: shift enable is combinational, window qualifiers appear PIPE_LAT cycles after the pixel.
// ivalid low stalls the counters only, never the qualifier pipeline; WINDOW_BORDER_EN also qualifies edge windows.
module window_scan_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIPE_LAT   = 2
) (
    input  logic                iclk,
    input  logic                irst_n,
    window_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DRAIN} state_t;

    typedef struct packed {
        logic       qual;
        logic       last;
        logic       border;
        logic [8:0] row;
        logic [9:0] col;
    } qual_t;

    localparam int         DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [9:0] COL_LAST   = 10'(IMG_WIDTH - 1);
    localparam logic [8:0] ROW_LAST   = 9'(IMG_HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    state_t               state, state_nxt;
    logic [9:0]           col, col_nxt, pix_col;
    logic [8:0]           row, row_nxt, pix_row;
    logic [DW-1:0]        drain_cnt, drain_nxt;
    logic                 err_q, err_nxt;
    logic                 accept, at_eol;
    qual_t                entry;
    qual_t [PIPE_LAT-1:0] pipe;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            drain_cnt <= drain_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        drain_nxt = drain_cnt;
        err_nxt   = 1'b0;
        accept    = bus.ivalid && (bus.isof || state == FILL || state == ACTIVE);
        // An accepted start-of-frame pixel is (0,0) regardless of where the counters were.
        pix_col   = bus.isof ? 10'd0 : col;
        pix_row   = bus.isof ? 9'd0  : row;
        at_eol    = (pix_col == COL_LAST);

        if (accept) begin
            if (bus.isof) begin
                err_nxt   = (state == FILL) || (state == ACTIVE);
                col_nxt   = 10'd1;
                row_nxt   = 9'd0;
                state_nxt = FILL;
            end else if (at_eol) begin
                col_nxt = 10'd0;
                row_nxt = row + 9'd1;
                if (row == ROW_LAST) begin
                    state_nxt = DRAIN;
                    row_nxt   = 9'd0;
                    drain_nxt = '0;
                end else if (row == 9'd1) begin
                    state_nxt = ACTIVE;
                end
            end else begin
                col_nxt = col + 10'd1;
            end
        end else if (state == DRAIN) begin
            if (drain_cnt == DRAIN_LAST) begin
                state_nxt = IDLE;
            end else begin
                drain_nxt = drain_cnt + DW'(1);
            end
        end

        entry      = '0;
        entry.row  = pix_row;
        entry.col  = pix_col;
        entry.last = accept && !bus.isof && at_eol && (row == ROW_LAST);
`ifdef WINDOW_BORDER_EN
        entry.qual   = accept;
        entry.border = (pix_row < 9'd2) || (pix_col < 10'd2);
`else
        entry.qual   = accept && (pix_row >= 9'd2) && (pix_col >= 10'd2);
        entry.border = 1'b0;
`endif
    end

    // Frame-done rides the pipeline so it lines up with the final window; a mid-frame restart drops everything in flight.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= entry;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe[i] <= err_nxt ? '0 : pipe[i-1];
            end
        end
    end

    assign bus.oshift_en   = accept;
    assign bus.ovalid      = pipe[PIPE_LAT-1].qual;
    assign bus.ocol        = pipe[PIPE_LAT-1].col;
    assign bus.orow        = pipe[PIPE_LAT-1].row;
    assign bus.oborder     = pipe[PIPE_LAT-1].border;
    assign bus.oframe_done = pipe[PIPE_LAT-1].last;
    assign bus.oerr_sof    = err_q;
    assign bus.obusy       = (state != IDLE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: pixel-index reference model schedules expected outputs on an absolute cycle timeline.
module tb_window_scan_ctrl;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int LAT  = 2;
    localparam int MAXC = 4096;
`ifdef WINDOW_BORDER_EN
    localparam bit BM = 1'b1;
`else
    localparam bit BM = 1'b0;
`endif
    localparam int FRAME_V   = BM ? W * H : (H - 2) * (W - 2);
    localparam int FRAME_B   = BM ? 24 : 0;
    // Restart at (3,4): pixel (3,3) is in flight and dropped, the rest of the aborted part survives.
    localparam int RESTART_V = BM ? 27 + W * H : 7 + FRAME_V;
    localparam int RESTART_B = BM ? 20 + FRAME_B : 0;

    logic iclk   = 1'b0;
    logic irst_n = 1'b1;

    window_scan_ctrl_if bus();

    window_scan_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIPE_LAT  (LAT)
    ) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .bus   (bus)
    );

    always #5 iclk = ~iclk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pix   = 0;
    int drain_end = -1;
    bit in_frame  = 1'b0;
    bit exp_v [MAXC];
    bit exp_d [MAXC];
    bit exp_e [MAXC];
    bit exp_b [MAXC];
    int exp_r [MAXC];
    int exp_c [MAXC];
    int obs_v, obs_b, obs_d, obs_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_future(input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_e[i] = 1'b0; exp_b[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check everything visible in this cycle, advance the model.
    task automatic step(input logic v, input logic s);
        bit acc;
        bit q;
        int r, c;
        bus.ivalid = v;
        bus.isof   = s;
        #1;
        acc = v && (s || in_frame);
        chk("shift_en", bus.oshift_en, acc);
        chk("busy", bus.obusy, in_frame || (cyc <= drain_end));
        chk("valid", bus.ovalid, exp_v[cyc]);
        if (exp_v[cyc]) begin
            chk("row", bus.orow, exp_r[cyc]);
            chk("col", bus.ocol, exp_c[cyc]);
            chk("border", bus.oborder, exp_b[cyc]);
        end
        chk("frame_done", bus.oframe_done, exp_d[cyc]);
        chk("err_sof", bus.oerr_sof, exp_e[cyc]);
        if (bus.ovalid === 1'b1) obs_v++;
        if (bus.ovalid === 1'b1 && bus.oborder === 1'b1) obs_b++;
        if (bus.oframe_done === 1'b1) obs_d++;
        if (bus.oerr_sof === 1'b1) obs_e++;

        if (acc) begin
            if (s) begin
                if (in_frame) begin
                    exp_e[cyc+1] = 1'b1;
                    for (int i = cyc + 1; i < cyc + LAT; i++) exp_v[i] = 1'b0;
                end
                pix      = 0;
                in_frame = 1'b1;
            end
            r = pix / W;
            c = pix % W;
            q = BM || (r >= 2 && c >= 2);
            if (q) begin
                exp_v[cyc+LAT] = 1'b1;
                exp_r[cyc+LAT] = r;
                exp_c[cyc+LAT] = c;
                exp_b[cyc+LAT] = BM && (r < 2 || c < 2);
            end
            pix++;
            if (pix == W * H) begin
                in_frame       = 1'b0;
                exp_d[cyc+LAT] = 1'b1;
                drain_end      = cyc + LAT;
            end
        end
        @(posedge iclk);
        @(negedge iclk);
        cyc++;
    endtask

    // mode 0: continuous, 1: alternate valid/idle, 2: random idle gaps (isof without ivalid in gaps).
    task automatic send(input int n, input int mode, input bit sof_first);
        for (int k = 0; k < n; k++) begin
            step(1'b1, sof_first && (k == 0));
            if (mode == 1) step(1'b0, 1'b0);
            if (mode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    // Outside a frame, ivalid without isof must be ignored.
    task automatic idle(input int n);
        repeat (n) step(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic seg_begin();
        obs_v = 0; obs_b = 0; obs_d = 0; obs_e = 0;
    endtask

    task automatic seg_end(input string tag, input int ev, input int eb, input int ed, input int ee);
        chk({tag, "_pulses"}, obs_v, ev);
        chk({tag, "_borders"}, obs_b, eb);
        chk({tag, "_done_cnt"}, obs_d, ed);
        chk({tag, "_err_cnt"}, obs_e, ee);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_shift_en"}, bus.oshift_en, 0);
        chk({tag, "_valid"}, bus.ovalid, 0);
        chk({tag, "_col"}, bus.ocol, 0);
        chk({tag, "_row"}, bus.orow, 0);
        chk({tag, "_border"}, bus.oborder, 0);
        chk({tag, "_done"}, bus.oframe_done, 0);
        chk({tag, "_err"}, bus.oerr_sof, 0);
        chk({tag, "_busy"}, bus.obusy, 0);
    endtask

    // Asynchronous reset mid-cycle with ivalid held high; lasts two cycles.
    task automatic do_reset();
        bus.ivalid = 1'b1;
        bus.isof   = 1'b0;
        #2 irst_n = 1'b0;
        #1;
        check_all_zero("reset");
        in_frame  = 1'b0;
        drain_end = -1;
        clear_future(cyc, LAT + 4);
        @(negedge iclk);
        @(negedge iclk);
        bus.ivalid = 1'b0;
        irst_n     = 1'b1;
        cyc += 2;
    endtask

    initial begin
        bus.ivalid = 1'b0;
        bus.isof   = 1'b0;
        #2 irst_n = 1'b0;
        #1;
        check_all_zero("por");
        @(negedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;
        cyc    = 0;

        idle(3);

        seg_begin();
        send(W * H, 0, 1'b1);
        idle(LAT + 3);
        seg_end("cont", FRAME_V, FRAME_B, 1, 0);

        seg_begin();
        send(W * H, 1, 1'b1);
        idle(LAT + 3);
        seg_end("toggle", FRAME_V, FRAME_B, 1, 0);

        seg_begin();
        send(W * H, 2, 1'b1);
        idle(LAT + 3);
        seg_end("gaps", FRAME_V, FRAME_B, 1, 0);

        seg_begin();
        send(3 * W + 4, 0, 1'b1);
        send(W * H, 0, 1'b1);
        idle(LAT + 3);
        seg_end("restart", RESTART_V, RESTART_B, 1, 1);

        seg_begin();
        send(W * H, 0, 1'b1);
        send(W * H, 0, 1'b1);
        idle(LAT + 3);
        seg_end("b2b", 2 * FRAME_V, 2 * FRAME_B, 2, 0);

        send(4 * W + 1, 0, 1'b1);
        do_reset();
        seg_begin();
        idle(2);
        send(W * H, 2, 1'b1);
        idle(LAT + 3);
        seg_end("post_reset", FRAME_V, FRAME_B, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
